// File: rtl/burst_decoder_pkg.sv
// burst_decoder_pkg: opcode, ALU and control encodings shared by the burst decode stage
package burst_decoder_pkg;
   typedef enum logic [2:0] {
      OP_DP   = 3'b000,
      OP_MEM  = 3'b001,
      OP_BR   = 3'b010,
      OP_RSV3 = 3'b011,
      OP_KRD  = 3'b100,
      OP_PST  = 3'b101,
      OP_PRD  = 3'b110,
      OP_RSV7 = 3'b111
   } op_e;
   typedef struct packed {
      logic [1:0] reg_src;
      logic [1:0] imm_src;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
   } dp_ctrl_t;
   typedef struct packed {
      dp_ctrl_t dp;
      logic     alu_op;
   } ctrl_word_t;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_EOR  = 4'b0110;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_RSB  = 4'b0111;
   localparam logic [3:0] ALU_ADD  = 4'b0011;
   localparam logic [3:0] ALU_ORR  = 4'b0101;
   localparam logic [3:0] ALU_MOV  = 4'b0001;
   localparam logic [3:0] ALU_MVN  = 4'b0100;
   localparam logic [3:0] ALU_NONE = 4'b1111;
   localparam logic [6:0] CTRL_KRD_WIDE = 7'b1101010;
   localparam logic [6:0] CTRL_KRD      = 7'b1100010;
   localparam logic [6:0] CTRL_PST      = 7'b0100001;
   localparam logic [6:0] CTRL_PRD      = 7'b1001110;
   function automatic logic is_burst_op(input op_e op);
      return op inside {OP_KRD, OP_PST, OP_PRD};
   endfunction
endpackage

// File: rtl/decode_rom.sv
// decode_rom: combinational Op/Funct to datapath control, Ctrl, ALUControl, FlagWrite and illegal flag
module decode_rom
   import burst_decoder_pkg::*;
(
   input  logic [2:0] op,
   input  logic [5:0] funct,
   output logic [8:0] dp,
   output logic [6:0] ctrl,
   output logic [3:0] alu_control,
   output logic [1:0] flag_write,
   output logic       illegal
);
   ctrl_word_t w;
   logic [3:0] alu_raw;
   logic       unknown_op, bad_funct;
   always_comb begin
      w = '0;
      ctrl = '0;
      unknown_op = 1'b0;
      case (op_e'(op))
         OP_DP:   w = funct[5] ? 10'b0000101001 : 10'b0000001001;
         OP_MEM:  w = funct[0] ? 10'b0001111000 : 10'b1001110100;
         OP_BR:   w = 10'b0010100010;
         OP_KRD:  begin w = 10'b0000011001; ctrl = funct[5] ? CTRL_KRD_WIDE : CTRL_KRD; end
         OP_PST:  begin w = 10'b1000100101; ctrl = CTRL_PST; end
         OP_PRD:  begin w = 10'b0000011001; ctrl = CTRL_PRD; end
         default: unknown_op = 1'b1;
      endcase
   end
   always_comb begin
      alu_raw = ALU_AND;
      bad_funct = 1'b0;
      case (funct[4:1])
         4'b0000: alu_raw = ALU_AND;
         4'b0001: alu_raw = ALU_EOR;
         4'b0010: alu_raw = ALU_SUB;
         4'b0011: alu_raw = ALU_RSB;
         4'b0100: alu_raw = ALU_ADD;
         4'b1100: alu_raw = ALU_ORR;
         4'b1101: alu_raw = ALU_MOV;
         4'b1111: alu_raw = ALU_MVN;
         default: bad_funct = 1'b1;
      endcase
   end
   assign dp = w.dp;
   // unknown opcodes force every control low, including the ALUOp=0 default of 1111
   assign alu_control = unknown_op ? 4'b0000 : (w.alu_op ? alu_raw : ALU_NONE);
   assign flag_write = w.alu_op ? {funct[0], funct[0] & (alu_raw == ALU_ADD || alu_raw == ALU_SUB)} : 2'b00;
   assign illegal = unknown_op | (w.alu_op & bad_funct);
endmodule

// File: rtl/burst_decoder.sv
// burst_decoder: registered decode stage that expands burst instructions into per-beat micro-ops
module burst_decoder
   import burst_decoder_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int PC_REG    = 15,
   parameter int MAX_BURST = 9,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValidD,
   input  logic [2:0]       Op,
   input  logic [5:0]       Funct,
   input  logic [REG_W-1:0] Rd,
   input  logic [CNT_W-1:0] BurstLen,
   input  logic             HoldE,
   output logic             BusyD,
   output logic             UopValid,
   output logic             UopLast,
   output logic [CNT_W-1:0] UopOffset,
   output logic [REG_W-1:0] UopRd,
   output logic             IllegalD,
   output logic [1:0]       RegSrc,
   output logic [1:0]       ImmSrcD,
   output logic             ALUSrcD,
   output logic             MemtoRegD,
   output logic             RegWriteD,
   output logic             MemWriteD,
   output logic             BranchD,
   output logic             PCSrcD,
   output logic [3:0]       ALUControlD,
   output logic [1:0]       FlagWriteD,
   output logic [6:0]       Ctrl
);
   logic [8:0]       dp_rom;
   dp_ctrl_t         dp_d, dp_q;
   logic [6:0]       ctrl_rom, ctrl_d, ctrl_q;
   logic [3:0]       alu_rom, alu_d, alu_q;
   logic [1:0]       fw_rom, fw_d, fw_q;
   logic             ill_rom, ill_d, ill_q, valid_d, valid_q, pcsrc_d, pcsrc_q;
   logic [CNT_W-1:0] beats, left_d, left_q, off_d, off_q;
   logic [REG_W-1:0] rd_d, rd_q;
   logic             busy, accept;
   decode_rom u_rom (
      .op          (Op),
      .funct       (Funct),
      .dp          (dp_rom),
      .ctrl        (ctrl_rom),
      .alu_control (alu_rom),
      .flag_write  (fw_rom),
      .illegal     (ill_rom)
   );
   assign busy = left_q != '0;
   assign accept = InstrValidD & ~busy & ~HoldE;
   assign beats = (!is_burst_op(op_e'(Op)) || BurstLen == '0) ? CNT_W'(1)
                : (BurstLen > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : BurstLen;
   always_comb begin
      dp_d = dp_q;
      ctrl_d = ctrl_q;
      alu_d = alu_q;
      fw_d = fw_q;
      ill_d = ill_q;
      valid_d = valid_q;
      left_d = left_q;
      off_d = off_q;
      rd_d = rd_q;
      if (busy && !HoldE) begin
         left_d = left_q - 1'b1;
         off_d = off_q + 1'b1;
         rd_d = rd_q + 1'b1;
      end else if (accept) begin
         dp_d = dp_rom;
         ctrl_d = ctrl_rom;
         alu_d = alu_rom;
         fw_d = fw_rom;
         ill_d = ill_rom;
         valid_d = 1'b1;
         left_d = beats - 1'b1;
         off_d = '0;
         rd_d = Rd;
      end else if (!HoldE) begin
         dp_d = '0;
         ctrl_d = '0;
         alu_d = '0;
         fw_d = '0;
         ill_d = 1'b0;
         valid_d = 1'b0;
         off_d = '0;
         rd_d = '0;
      end
      // recomputed from the beat's own destination so a wrapped beat can hit the PC
      pcsrc_d = ((rd_d == REG_W'(PC_REG)) & dp_d.reg_write) | dp_d.branch;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_q <= '0;
         ctrl_q <= '0;
         alu_q <= '0;
         fw_q <= '0;
         ill_q <= 1'b0;
         valid_q <= 1'b0;
         pcsrc_q <= 1'b0;
         left_q <= '0;
         off_q <= '0;
         rd_q <= '0;
      end else begin
         dp_q <= dp_d;
         ctrl_q <= ctrl_d;
         alu_q <= alu_d;
         fw_q <= fw_d;
         ill_q <= ill_d;
         valid_q <= valid_d;
         pcsrc_q <= pcsrc_d;
         left_q <= left_d;
         off_q <= off_d;
         rd_q <= rd_d;
      end
   end
   assign BusyD = busy;
   assign UopValid = valid_q;
   assign UopLast = valid_q & ~busy;
   assign UopOffset = off_q;
   assign UopRd = rd_q;
   assign IllegalD = ill_q;
   assign RegSrc = dp_q.reg_src;
   assign ImmSrcD = dp_q.imm_src;
   assign ALUSrcD = dp_q.alu_src;
   assign MemtoRegD = dp_q.mem_to_reg;
   assign RegWriteD = dp_q.reg_write;
   assign MemWriteD = dp_q.mem_write;
   assign BranchD = dp_q.branch;
   assign PCSrcD = pcsrc_q;
   assign ALUControlD = alu_q;
   assign FlagWriteD = fw_q;
   assign Ctrl = ctrl_q;
endmodule

// File: tb/tb_burst_decoder.sv
// tb_burst_decoder: directed checks of decode, burst sequencing, hold, wrap and reset behaviour
module tb_burst_decoder;
   logic       clk = 1'b0, reset = 1'b0, InstrValidD = 1'b0, HoldE = 1'b0;
   logic [2:0] Op = '0;
   logic [5:0] Funct = '0;
   logic [4:0] Rd = '0;
   logic [3:0] BurstLen = '0;
   logic       BusyD, UopValid, UopLast, IllegalD, ALUSrcD, MemtoRegD, RegWriteD, MemWriteD, BranchD, PCSrcD;
   logic [3:0] UopOffset, ALUControlD;
   logic [4:0] UopRd;
   logic [1:0] RegSrc, ImmSrcD, FlagWriteD;
   logic [6:0] Ctrl;
   logic [22:0] ctl;
   logic [12:0] st;
   int n_chk = 0, n_fail = 0;
   // ctl = {RegSrc,ImmSrc,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,PCSrc,ALUControl,FlagWrite,Ctrl}
   localparam logic [22:0] ADD_CTL  = {9'b000000100, 1'b0, 4'b0011, 2'b11, 7'b0000000};
   localparam logic [22:0] KRDW_CTL = {9'b000001100, 1'b0, 4'b0000, 2'b00, 7'b1101010};
   localparam logic [22:0] KRD_CTL  = {9'b000001100, 1'b0, 4'b0000, 2'b00, 7'b1100010};
   localparam logic [22:0] PRD_CTL  = {9'b000001100, 1'b0, 4'b0000, 2'b00, 7'b1001110};
   localparam logic [22:0] PST_CTL  = {9'b100010010, 1'b0, 4'b0000, 2'b00, 7'b0100001};
   localparam logic [22:0] BR_CTL   = {9'b001010001, 1'b1, 4'b1111, 2'b00, 7'b0000000};
   localparam logic [22:0] MEM_CTL  = {9'b000111100, 1'b1, 4'b1111, 2'b00, 7'b0000000};
   localparam logic [12:0] ADD_ST   = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd3};
   assign ctl = {RegSrc, ImmSrcD, ALUSrcD, MemtoRegD, RegWriteD, MemWriteD, BranchD, PCSrcD, ALUControlD, FlagWriteD, Ctrl};
   assign st = {UopValid, UopLast, BusyD, IllegalD, UopOffset, UopRd};
   burst_decoder dut (
      .clk(clk), .reset(reset), .InstrValidD(InstrValidD), .Op(Op), .Funct(Funct), .Rd(Rd),
      .BurstLen(BurstLen), .HoldE(HoldE), .BusyD(BusyD), .UopValid(UopValid), .UopLast(UopLast),
      .UopOffset(UopOffset), .UopRd(UopRd), .IllegalD(IllegalD), .RegSrc(RegSrc), .ImmSrcD(ImmSrcD),
      .ALUSrcD(ALUSrcD), .MemtoRegD(MemtoRegD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .Ctrl(Ctrl)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [2:0] o, input logic [5:0] f, input logic [4:0] r, input logic [3:0] l);
      InstrValidD = v;
      Op = o;
      Funct = f;
      Rd = r;
      BurstLen = l;
   endtask
   task automatic test_reset;
      drive(1'b1, 3'b000, 6'b001001, 5'd3, 4'd0);
      reset = 1'b1;
      tick;
      tick;
      n_chk++; if ({ctl, st} !== 36'd0) begin n_fail++; $display("FAIL reset_state got ctl=%h st=%h want 0", ctl, st); end
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      #2 reset = 1'b0;
   endtask
   task automatic test_add;
      drive(1'b1, 3'b000, 6'b001001, 5'd3, 4'd0);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      n_chk++; if (ctl !== ADD_CTL) begin n_fail++; $display("FAIL add_ctl got %h want %h", ctl, ADD_CTL); end
      n_chk++; if (st !== ADD_ST) begin n_fail++; $display("FAIL add_st got %h want %h", st, ADD_ST); end
      tick;
      n_chk++; if ({ctl, st} !== 36'd0) begin n_fail++; $display("FAIL add_bubble got ctl=%h st=%h want 0", ctl, st); end
   endtask
   task automatic test_kernel;
      logic [12:0] e;
      drive(1'b1, 3'b100, 6'b100000, 5'd4, 4'd9);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick;
         e = {1'b1, i == 8, i < 8, 1'b0, 4'(i), 5'(4 + i)};
         n_chk++; if ({ctl, st} !== {KRDW_CTL, e}) begin n_fail++; $display("FAIL kernel beat %0d got ctl=%h st=%h want ctl=%h st=%h", i, ctl, st, KRDW_CTL, e); end
      end
      tick;
      n_chk++; if ({ctl, st} !== 36'd0) begin n_fail++; $display("FAIL kernel_end got ctl=%h st=%h want 0", ctl, st); end
   endtask
   task automatic test_back_to_back;
      logic [12:0] e;
      drive(1'b1, 3'b110, 6'b000000, 5'd7, 4'd3);
      tick;
      drive(1'b1, 3'b000, 6'b001001, 5'd3, 4'd0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick;
         e = {1'b1, i == 2, i < 2, 1'b0, 4'(i), 5'(7 + i)};
         n_chk++; if ({ctl, st} !== {PRD_CTL, e}) begin n_fail++; $display("FAIL b2b beat %0d got ctl=%h st=%h want ctl=%h st=%h", i, ctl, st, PRD_CTL, e); end
      end
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      n_chk++; if ({ctl, st} !== {ADD_CTL, ADD_ST}) begin n_fail++; $display("FAIL b2b_add got ctl=%h st=%h want ctl=%h st=%h", ctl, st, ADD_CTL, ADD_ST); end
      tick;
      n_chk++; if (st !== 13'd0) begin n_fail++; $display("FAIL b2b_bubble got st=%h want 0", st); end
   endtask
   task automatic test_hold;
      logic [12:0] e;
      HoldE = 1'b1;
      drive(1'b1, 3'b101, 6'b000000, 5'd20, 4'd4);
      tick;
      n_chk++; if (st !== 13'd0) begin n_fail++; $display("FAIL hold_blocks_accept got st=%h want 0", st); end
      HoldE = 1'b0;
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      tick;
      e = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 5'd21};
      n_chk++; if ({ctl, st} !== {PST_CTL, e}) begin n_fail++; $display("FAIL hold_beat1 got ctl=%h st=%h want ctl=%h st=%h", ctl, st, PST_CTL, e); end
      HoldE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_chk++; if ({ctl, st} !== {PST_CTL, e}) begin n_fail++; $display("FAIL hold_frozen %0d got ctl=%h st=%h want ctl=%h st=%h", i, ctl, st, PST_CTL, e); end
      end
      HoldE = 1'b0;
      tick;
      e = {1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 5'd22};
      n_chk++; if (st !== e) begin n_fail++; $display("FAIL hold_beat2 got st=%h want %h", st, e); end
      tick;
      e = {1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 5'd23};
      n_chk++; if ({ctl, st} !== {PST_CTL, e}) begin n_fail++; $display("FAIL hold_beat3 got ctl=%h st=%h want ctl=%h st=%h", ctl, st, PST_CTL, e); end
      tick;
   endtask
   task automatic test_boundaries;
      logic [12:0] e;
      drive(1'b1, 3'b100, 6'b000000, 5'd1, 4'd0);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      e = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1};
      n_chk++; if ({ctl, st} !== {KRD_CTL, e}) begin n_fail++; $display("FAIL len0 got ctl=%h st=%h want ctl=%h st=%h", ctl, st, KRD_CTL, e); end
      tick;
      n_chk++; if (st !== 13'd0) begin n_fail++; $display("FAIL len0_end got st=%h want 0", st); end
      drive(1'b1, 3'b110, 6'b000000, 5'd0, 4'd15);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick;
         e = {1'b1, i == 8, i < 8, 1'b0, 4'(i), 5'(i)};
         n_chk++; if (st !== e) begin n_fail++; $display("FAIL len15 beat %0d got st=%h want %h", i, st, e); end
      end
      tick;
      n_chk++; if (st !== 13'd0) begin n_fail++; $display("FAIL len15_end got st=%h want 0", st); end
      drive(1'b1, 3'b110, 6'b000000, 5'd30, 4'd4);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick;
         e = {1'b1, i == 3, i < 3, 1'b0, 4'(i), 5'(30 + i)};
         n_chk++; if (st !== e) begin n_fail++; $display("FAIL wrap beat %0d got st=%h want %h", i, st, e); end
      end
      tick;
      drive(1'b1, 3'b110, 6'b000000, 5'd14, 4'd2);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      n_chk++; if ({PCSrcD, UopRd} !== {1'b0, 5'd14}) begin n_fail++; $display("FAIL pcsrc_beat0 got pcsrc=%b rd=%0d want 0 14", PCSrcD, UopRd); end
      tick;
      n_chk++; if ({PCSrcD, UopRd} !== {1'b1, 5'd15}) begin n_fail++; $display("FAIL pcsrc_beat1 got pcsrc=%b rd=%0d want 1 15", PCSrcD, UopRd); end
      drive(1'b1, 3'b111, 6'b101010, 5'd15, 4'd5);
      tick;
      e = {1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 5'd15};
      n_chk++; if ({ctl, st} !== {23'd0, e}) begin n_fail++; $display("FAIL illegal_op got ctl=%h st=%h want ctl=0 st=%h", ctl, st, e); end
      drive(1'b1, 3'b010, 6'b000000, 5'd0, 4'd0);
      tick;
      n_chk++; if (ctl !== BR_CTL) begin n_fail++; $display("FAIL branch got %h want %h", ctl, BR_CTL); end
      drive(1'b1, 3'b001, 6'b000001, 5'd15, 4'd3);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      e = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd15};
      n_chk++; if ({ctl, st} !== {MEM_CTL, e}) begin n_fail++; $display("FAIL mem_pc got ctl=%h st=%h want ctl=%h st=%h", ctl, st, MEM_CTL, e); end
      tick;
   endtask
   task automatic test_alu_table;
      logic [3:0] f4 [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b0101, 4'b1110};
      logic [6:0] ex [10] = '{7'b0000_10_0, 7'b0110_10_0, 7'b0010_11_0, 7'b0111_10_0, 7'b0011_11_0,
                              7'b0101_10_0, 7'b0001_10_0, 7'b0100_10_0, 7'b0000_10_1, 7'b0000_10_1};
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 3'b000, {1'b0, f4[i], 1'b1}, 5'd0, 4'd0);
         tick;
         n_chk++; if ({ALUControlD, FlagWriteD, IllegalD} !== ex[i]) begin n_fail++; $display("FAIL alu funct %b got %b want %b", f4[i], {ALUControlD, FlagWriteD, IllegalD}, ex[i]); end
      end
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      tick;
   endtask
   task automatic test_reset_mid;
      drive(1'b1, 3'b100, 6'b000000, 5'd2, 4'd4);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      tick;
      tick;
      n_chk++; if ({UopOffset, BusyD} !== {4'd2, 1'b1}) begin n_fail++; $display("FAIL rst_mid_pre got off=%0d busy=%b want 2 1", UopOffset, BusyD); end
      #2 reset = 1'b1;
      #1;
      n_chk++; if ({ctl, st} !== 36'd0) begin n_fail++; $display("FAIL rst_mid_async got ctl=%h st=%h want 0", ctl, st); end
      #1 reset = 1'b0;
      drive(1'b1, 3'b000, 6'b001001, 5'd3, 4'd0);
      tick;
      drive(1'b0, 3'b000, 6'b0, 5'd0, 4'd0);
      n_chk++; if ({ctl, st} !== {ADD_CTL, ADD_ST}) begin n_fail++; $display("FAIL rst_mid_accept got ctl=%h st=%h want ctl=%h st=%h", ctl, st, ADD_CTL, ADD_ST); end
      tick;
      n_chk++; if (st !== 13'd0) begin n_fail++; $display("FAIL rst_mid_residual got st=%h want 0", st); end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset;
      test_add;
      test_kernel;
      test_back_to_back;
      test_hold;
      test_boundaries;
      test_alu_table;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
